output_port_sched: RTL
======================

OUTPUT_PORT_SCHED -- requirements
Module: output_port_sched

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DEPTH, 4, downstream input-buffer depth in flits; also the reset credit count.
- CW, 3, credit counter width; SHALL satisfy 2^CW > DEPTH.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  5  bit i: input port i (0..4) presents a flit for this output.
- flit_tail  input  5  bit i: the flit presented by port i is a tail flit (single-flit packet = head+tail).
- credit_in  input  1  one-cycle pulse; downstream freed one buffer slot.
- gnt  output  5  one-hot registered grant; bit i = port i owns the output.
- fwd  output  1  combinational; a flit transfers this cycle.
- credits  output  CW  current credit count.
- busy  output  1  high while the FSM is in LOCKED.
- cred_err  output  1  sticky credit-overflow flag.

Function
REQ-003 FSM SHALL have exactly two states, IDLE and LOCKED, with an owner register own[2:0] and a round-robin pointer ptr[2:0] in the range 0..4.
REQ-004 In IDLE with req != 0, the block SHALL select the first asserted req bit in search order ptr, ptr+1, ..., ptr+4 (mod 5), load own, set gnt to one-hot(own), and enter LOCKED at the next edge.
REQ-005 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-006 Grant latency SHALL be exactly 1 cycle from req sampled in IDLE to gnt asserted.
REQ-007 In LOCKED, fwd SHALL equal req[own] AND (credits != 0); in IDLE, fwd SHALL be 0.
REQ-008 In LOCKED, fwd AND flit_tail[own] SHALL cause, at the next edge, state = IDLE, gnt = 0, and ptr = (own+1) mod 5.
REQ-009 In LOCKED, deassertion of req[own] without a tail transfer SHALL keep the lock, with gnt held and no re-arbitration (wormhole).
REQ-010 Requests from non-owner ports SHALL be ignored while LOCKED.
REQ-011 Minimum spacing between packets SHALL be one IDLE cycle after each tail transfer.
REQ-012 The credits next value SHALL be credits - fwd + credit_in.
- Simultaneous fwd and credit_in SHALL leave credits unchanged.
REQ-013 credit_in while credits == DEPTH and fwd == 0 SHALL leave credits at DEPTH and set cred_err = 1.
- cred_err SHALL hold until rst.
REQ-014 credits == 0 SHALL force fwd = 0 with the grant held.
- credits SHALL never wrap below 0.
REQ-015 busy SHALL be 1 exactly when state == LOCKED.
- gnt SHALL be 0 or one-hot at all times.

Reset
REQ-016 When rst is sampled high, the next edge SHALL set: state = IDLE, gnt = 0, own = 0, ptr = 0, credits = DEPTH, cred_err = 0, busy = 0.
- fwd = 0 SHALL follow combinationally.
REQ-017 rst SHALL take priority over all events, including mid-packet.
- The abandoned packet SHALL NOT be resumed.

Verification
REQ-018 Single packet: after reset, req = 00001 held, flit_tail[0] on 3rd flit, no credit_in.
- gnt = 00001 one cycle after req.
- fwd high 3 cycles; credits 4 -> 1.
- gnt = 0 and busy = 0 the cycle after the tail.
REQ-019 Round-robin: after reset, req = 11111 constant, flit_tail = 11111, credit_in = 1 every cycle.
- Grant sequence 0, 1, 2, 3, 4, 0, each grant lasting 1 cycle and separated by 1 IDLE cycle.
- credits stays 4.
REQ-020 Credit stall: DEPTH = 4, 6-flit packet on port 2, no credit_in.
- fwd for 4 cycles, then fwd = 0 with gnt = 00100 held.
- Each credit_in pulse yields exactly one further fwd.
REQ-021 Simultaneous events: fwd and credit_in in the same cycle at credits = 2 -> credits stays 2.
- credit_in at credits = 4 with no fwd -> credits = 4 and cred_err = 1, persisting until rst.
REQ-022 Mid-packet reset: rst during LOCKED on port 3 with credits = 1.
- Next cycle: gnt = 0, credits = 4, ptr = 0.
- Subsequent req = 11000 grants port 3.
REQ-023 Lock hold: owner port 1 drops req for 5 cycles mid-packet while req[4] = 1.
- gnt stays 00010 and fwd = 0 throughout.
- The packet resumes when req[1] returns.

Source files
------------

// File: rtl/output_port_sched.sv
// Output-port scheduler for a 5-input wormhole router.
// An IDLE/LOCKED FSM grants the output to one input port, chosen round-robin.
// The grant holds until that port's tail flit transfers. Flits move only while
// downstream credits are available.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req[4:0]      per-input-port flit request
//   flit_tail[4:0] per-input-port tail marker for the presented flit
//   credit_in     downstream freed one buffer slot (one-cycle pulse)
//   gnt[4:0]      registered one-hot grant (0 when idle)
//   fwd           combinational: a flit transfers this cycle
//   credits       current downstream credit count
//   busy          FSM is in LOCKED
//   cred_err      sticky credit-overflow flag
module output_port_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req,
    input  logic [4:0]    flit_tail,
    input  logic          credit_in,
    output logic [4:0]    gnt,
    output logic          fwd,
    output logic [CW-1:0] credits,
    output logic          busy,
    output logic          cred_err
);

    localparam int unsigned NP = 5;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    // The credit counter must be able to hold DEPTH.
    if ((1 << CW) <= DEPTH) begin : g_bad_cw
        $error("output_port_sched: CW too narrow for DEPTH");
    end

    logic [0:0]    r_state;
    logic [2:0]    r_own;
    logic [2:0]    r_ptr;
    logic [NP-1:0] r_gnt;
    logic [CW-1:0] r_credits;
    logic          r_cred_err;
    logic          r_busy;

    logic [0:0]    w_nxt_state;
    logic [2:0]    w_nxt_own;
    logic [2:0]    w_nxt_ptr;
    logic [NP-1:0] w_nxt_gnt;
    logic [CW-1:0] w_nxt_credits;
    logic          w_nxt_cred_err;
    logic          w_arb_found;
    logic [2:0]    w_arb_idx;
    logic          w_fwd;

    // (a + b) mod 5 for operands already in 0..4
    function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd5) begin
            s = s - 4'd5;
        end
        return s[2:0];
    endfunction

    // Round-robin search from r_ptr; the loop runs backwards so the nearest hit wins.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = 3'd0;
        for (int k = NP - 1; k >= 0; k--) begin
            if (req[mod5_add(r_ptr, 3'(k))]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = mod5_add(r_ptr, 3'(k));
            end
        end
    end

    // Transfer needs the lock, the owner's request, and a downstream slot.
    assign w_fwd = (r_state == S_LOCKED) && req[r_own] && (r_credits != '0);

    // Next-state logic for the FSM, owner, pointer and grant
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_own   = r_own;
        w_nxt_ptr   = r_ptr;
        w_nxt_gnt   = r_gnt;
        case (r_state)
            S_IDLE: begin
                w_nxt_gnt = '0;
                if (w_arb_found) begin
                    w_nxt_state = S_LOCKED;
                    w_nxt_own   = w_arb_idx;
                    w_nxt_gnt   = NP'(1) << w_arb_idx;
                end
            end
            S_LOCKED: begin
                // Only a transferred tail releases the lock; a dropped request just stalls.
                if (w_fwd && flit_tail[r_own]) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_gnt   = '0;
                    w_nxt_ptr   = mod5_add(r_own, 3'd1);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_gnt   = '0;
            end
        endcase
    end

    // Credit accounting: consume on fwd, return on credit_in, saturate at DEPTH.
    always_comb begin
        w_nxt_credits  = r_credits;
        w_nxt_cred_err = r_cred_err;
        if (w_fwd && !credit_in) begin
            w_nxt_credits = r_credits - CW'(1);
        end else if (!w_fwd && credit_in) begin
            if (r_credits == CW'(DEPTH)) begin
                w_nxt_cred_err = 1'b1;
            end else begin
                w_nxt_credits = r_credits + CW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_own      <= 3'd0;
            r_ptr      <= 3'd0;
            r_gnt      <= '0;
            r_credits  <= CW'(DEPTH);
            r_cred_err <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_own      <= w_nxt_own;
            r_ptr      <= w_nxt_ptr;
            r_gnt      <= w_nxt_gnt;
            r_credits  <= w_nxt_credits;
            r_cred_err <= w_nxt_cred_err;
            r_busy     <= (w_nxt_state == S_LOCKED);
        end
    end

    assign gnt      = r_gnt;
    assign fwd      = w_fwd;
    assign credits  = r_credits;
    assign busy     = r_busy;
    assign cred_err = r_cred_err;

endmodule
